// File: rtl/secuenciador_muestras_pkg.sv
// Shared constants for the sample sequencer: FSM state encoding and overrun counter width.
package secuenciador_muestras_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_CAPT   = 2'd3;

    localparam int unsigned OVR_W = 8;

endpackage

// File: rtl/secuenciador_muestras_gen_tick_muestreo.sv
// Sample-rate divider: one-cycle tick every DIV clocks while en is high.
// Dropping en returns the count to zero so the next period starts clean.
module gen_tick_muestreo #(
    parameter int unsigned DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/secuenciador_muestras.sv
// Sample sequencer: latches ADC samples on the rate tick, runs the start/done handshake
// with the filter controller and strobes the result to the DAC. Optional: SEC_MUESTRAS_OVR_CNT_EN.
module secuenciador_muestras
    import secuenciador_muestras_pkg::*;
#(
    parameter int unsigned DIV     = 100,
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr_err,
    input  logic [W-1:0]     adc_dato,
    input  logic             Band_Listo,
    input  logic [W-1:0]     filt_dato,
    output logic             Bandera,
    output logic [W-1:0]     muestra_x,
    output logic [W-1:0]     dac_dato,
    output logic             dac_valido,
    output logic             ocupado,
    output logic             error_to,
    output logic [OVR_W-1:0] ovr_cnt
);

    localparam int unsigned WCW = $clog2(TIMEOUT) + 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    logic tick;

    gen_tick_muestreo #(
        .DIV (DIV)
    ) u_gen_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    logic [1:0]     state_q,      state_d;
    logic [W-1:0]   muestra_q,    muestra_d;
    logic [W-1:0]   dac_dato_q,   dac_dato_d;
    logic           dac_valido_q, dac_valido_d;
    logic           error_q,      error_d;
    logic [WCW-1:0] wait_cnt_q,   wait_cnt_d;
    logic           listo_prev_q, listo_prev_d;
    logic           done;
    logic           err_set;

    // The controller's Listo idles high, so only a rising edge counts as done.
    assign done = Band_Listo && !listo_prev_q;

    always_comb begin
        state_d      = state_q;
        muestra_d    = muestra_q;
        dac_dato_d   = dac_dato_q;
        dac_valido_d = 1'b0;
        wait_cnt_d   = wait_cnt_q;
        listo_prev_d = Band_Listo;
        err_set      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    muestra_d = adc_dato;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + WCW'(1);
                if (done) begin
                    state_d = ST_CAPT;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    err_set = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CAPT: begin
                dac_dato_d   = filt_dato;
                dac_valido_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A clear requested in the same cycle as a new timeout wins.
    always_comb begin
        error_d = error_q;
        if (clr_err) begin
            error_d = 1'b0;
        end else if (err_set) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            muestra_q    <= '0;
            dac_dato_q   <= '0;
            dac_valido_q <= 1'b0;
            error_q      <= 1'b0;
            wait_cnt_q   <= '0;
            listo_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            muestra_q    <= muestra_d;
            dac_dato_q   <= dac_dato_d;
            dac_valido_q <= dac_valido_d;
            error_q      <= error_d;
            wait_cnt_q   <= wait_cnt_d;
            listo_prev_q <= listo_prev_d;
        end
    end

`ifdef SEC_MUESTRAS_OVR_CNT_EN
    logic             tick_drop;
    logic [OVR_W-1:0] ovr_q;
    logic [OVR_W-1:0] ovr_d;

    assign tick_drop = tick && (state_q != ST_IDLE);

    always_comb begin
        ovr_d = ovr_q;
        if (clr_err) begin
            ovr_d = '0;
        end else if (tick_drop && (ovr_q != {OVR_W{1'b1}})) begin
            ovr_d = ovr_q + OVR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign ovr_cnt = ovr_q;
`else
    assign ovr_cnt = '0;
`endif

    assign Bandera    = (state_q == ST_LAUNCH);
    assign ocupado    = (state_q != ST_IDLE);
    assign muestra_x  = muestra_q;
    assign dac_dato   = dac_dato_q;
    assign dac_valido = dac_valido_q;
    assign error_to   = error_q;

endmodule

// File: tb/tb_secuenciador_muestras.sv
// Directed bench for secuenciador_muestras (DIV=8, TIMEOUT=10, W=16); expected ovr_cnt
// values scale with SEC_MUESTRAS_OVR_CNT_EN.
module tb_secuenciador_muestras;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr_err;
    logic [15:0] adc_dato;
    logic        band_listo;
    logic [15:0] filt_dato;
    logic        bandera;
    logic [15:0] muestra_x;
    logic [15:0] dac_dato;
    logic        dac_valido;
    logic        ocupado;
    logic        error_to;
    logic [7:0]  ovr_cnt;

    int checks   = 0;
    int failures = 0;
    int ovr_unit;

    secuenciador_muestras #(
        .DIV     (8),
        .W       (16),
        .TIMEOUT (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr_err    (clr_err),
        .adc_dato   (adc_dato),
        .Band_Listo (band_listo),
        .filt_dato  (filt_dato),
        .Bandera    (bandera),
        .muestra_x  (muestra_x),
        .dac_dato   (dac_dato),
        .dac_valido (dac_valido),
        .ocupado    (ocupado),
        .error_to   (error_to),
        .ovr_cnt    (ovr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef SEC_MUESTRAS_OVR_CNT_EN
        ovr_unit = 1;
`else
        ovr_unit = 0;
`endif
        rst_n      = 1'b0;
        en         = 1'b0;
        clr_err    = 1'b0;
        adc_dato   = 16'h0;
        band_listo = 1'b0;
        filt_dato  = 16'h0;
        #2;
        checkOutput("rst_bandera", 32'(bandera), 32'd0);
        checkOutput("rst_muestra", 32'(muestra_x), 32'd0);
        checkOutput("rst_dac_dato", 32'(dac_dato), 32'd0);
        checkOutput("rst_dac_valido", 32'(dac_valido), 32'd0);
        checkOutput("rst_ocupado", 32'(ocupado), 32'd0);
        checkOutput("rst_error", 32'(error_to), 32'd0);
        checkOutput("rst_ovr", 32'(ovr_cnt), 32'd0);
        applyStimulus(2);
        rst_n = 1'b1;
        applyStimulus(1);

        // Normal transaction: done edge six cycles after the start pulse.
        en        = 1'b1;
        adc_dato  = 16'h1234;
        filt_dato = 16'hBEEF;
        applyStimulus(7);
        checkOutput("t1_pre_bandera", 32'(bandera), 32'd0);
        checkOutput("t1_pre_ocupado", 32'(ocupado), 32'd0);
        applyStimulus(1);
        checkOutput("t1_bandera", 32'(bandera), 32'd1);
        checkOutput("t1_muestra", 32'(muestra_x), 32'h1234);
        checkOutput("t1_ocupado", 32'(ocupado), 32'd1);
        adc_dato = 16'h5555;
        applyStimulus(1);
        checkOutput("t1_bandera_drop", 32'(bandera), 32'd0);
        applyStimulus(5);
        band_listo = 1'b1;
        applyStimulus(1);
        checkOutput("t1_capt_valido", 32'(dac_valido), 32'd0);
        applyStimulus(1);
        checkOutput("t1_valido", 32'(dac_valido), 32'd1);
        checkOutput("t1_dac_dato", 32'(dac_dato), 32'hBEEF);
        checkOutput("t1_idle", 32'(ocupado), 32'd0);
        checkOutput("t1_capt_overrun_muestra", 32'(muestra_x), 32'h1234);
        checkOutput("t1_capt_overrun_ovr", 32'(ovr_cnt), 32'(ovr_unit));
        applyStimulus(1);
        checkOutput("t1_valido_single", 32'(dac_valido), 32'd0);
        checkOutput("t1_dac_hold", 32'(dac_dato), 32'hBEEF);
        en = 1'b0;
        applyStimulus(2);

        // Listo stuck high: no rising edge, transaction times out.
        en       = 1'b1;
        adc_dato = 16'h2222;
        applyStimulus(8);
        checkOutput("t2_bandera", 32'(bandera), 32'd1);
        checkOutput("t2_muestra", 32'(muestra_x), 32'h2222);
        adc_dato = 16'h7777;
        applyStimulus(8);
        checkOutput("t2_drop_muestra", 32'(muestra_x), 32'h2222);
        checkOutput("t2_waiting", 32'(ocupado), 32'd1);
        applyStimulus(2);
        checkOutput("t2_pre_to_error", 32'(error_to), 32'd0);
        checkOutput("t2_pre_to_ocupado", 32'(ocupado), 32'd1);
        applyStimulus(1);
        checkOutput("t2_error", 32'(error_to), 32'd1);
        checkOutput("t2_abort_idle", 32'(ocupado), 32'd0);
        checkOutput("t2_no_valido", 32'(dac_valido), 32'd0);
        checkOutput("t2_ovr", 32'(ovr_cnt), 32'(2 * ovr_unit));
        adc_dato = 16'h0A0A;
        applyStimulus(5);
        checkOutput("t2_relaunch", 32'(bandera), 32'd1);
        checkOutput("t2_relaunch_muestra", 32'(muestra_x), 32'h0A0A);

        // Clear while flagged, then clear coincident with a timeout.
        applyStimulus(8);
        checkOutput("t3_error_before_clr", 32'(error_to), 32'd1);
        checkOutput("t3_ovr_before_clr", 32'(ovr_cnt), 32'(3 * ovr_unit));
        clr_err = 1'b1;
        applyStimulus(1);
        checkOutput("t3_error_cleared", 32'(error_to), 32'd0);
        checkOutput("t3_ovr_cleared", 32'(ovr_cnt), 32'd0);
        clr_err = 1'b0;
        applyStimulus(1);
        checkOutput("t3_to_cycle_busy", 32'(ocupado), 32'd1);
        clr_err = 1'b1;
        applyStimulus(1);
        checkOutput("t3_clr_beats_timeout", 32'(error_to), 32'd0);
        checkOutput("t3_timeout_idle", 32'(ocupado), 32'd0);
        clr_err = 1'b0;
        en      = 1'b0;
        applyStimulus(2);

        // Reset pulse in the middle of WAIT.
        en         = 1'b1;
        band_listo = 1'b0;
        adc_dato   = 16'h3333;
        applyStimulus(8);
        checkOutput("t4_bandera", 32'(bandera), 32'd1);
        applyStimulus(2);
        rst_n = 1'b0;
        #1;
        checkOutput("t4_async_ocupado", 32'(ocupado), 32'd0);
        checkOutput("t4_async_bandera", 32'(bandera), 32'd0);
        checkOutput("t4_async_muestra", 32'(muestra_x), 32'd0);
        checkOutput("t4_async_dac_dato", 32'(dac_dato), 32'd0);
        checkOutput("t4_async_valido", 32'(dac_valido), 32'd0);
        checkOutput("t4_async_error", 32'(error_to), 32'd0);
        checkOutput("t4_async_ovr", 32'(ovr_cnt), 32'd0);
        applyStimulus(1);
        rst_n = 1'b1;
        applyStimulus(7);
        checkOutput("t4_first_tick_pre", 32'(bandera), 32'd0);
        applyStimulus(1);
        checkOutput("t4_first_tick", 32'(bandera), 32'd1);
        checkOutput("t4_muestra", 32'(muestra_x), 32'h3333);

        // en dropped mid-WAIT: transaction still completes.
        filt_dato = 16'hCAFE;
        applyStimulus(2);
        en = 1'b0;
        applyStimulus(2);
        band_listo = 1'b1;
        applyStimulus(1);
        checkOutput("t5_capt_valido", 32'(dac_valido), 32'd0);
        checkOutput("t5_capt_ocupado", 32'(ocupado), 32'd1);
        applyStimulus(1);
        checkOutput("t5_valido", 32'(dac_valido), 32'd1);
        checkOutput("t5_dac_dato", 32'(dac_dato), 32'hCAFE);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1);
            checkOutput("t5_en_low_no_bandera", 32'(bandera), 32'd0);
        end
        en = 1'b1;
        applyStimulus(7);
        checkOutput("t5_reen_pre", 32'(bandera), 32'd0);
        applyStimulus(1);
        checkOutput("t5_reen_bandera", 32'(bandera), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/secuenciador_muestras.md
Name: secuenciador_muestras

Overview:
- Initiator side of the filter-controller start/done handshake.
- Generates the sample-rate tick and latches the ADC sample into the filter datapath input.
- Pulses the filter start flag, waits for the controller's done flag, then captures the filter result and presents it to the DAC with a one-cycle valid.
- Sits between the ADC/DAC interface logic and the filter control/datapath pair.

Parameters:
- DIV, 100: clk cycles per sample period (≥ 8).
- W, 16: sample/result data width.
- TIMEOUT, 32: max cycles waiting for done before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  enables sample tick generation; low holds the divider at 0.
- clr_err  in  1  synchronous clear of error_to and ovr_cnt.
- adc_dato  in  W  current ADC sample.
- Band_Listo  in  1  done flag from filter controller.
- filt_dato  in  W  filter datapath result.
- Bandera  out  1  start pulse to filter controller.
- muestra_x  out  W  latched sample driven to filter datapath.
- dac_dato  out  W  registered filter result.
- dac_valido  out  1  one-cycle strobe, dac_dato new.
- ocupado  out  1  high while not in IDLE.
- error_to  out  1  sticky timeout flag.
- ovr_cnt  out  8  overrun counter (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state IDLE; divider=0; all outputs 0, including muestra_x, dac_dato and ovr_cnt.
- Divider:
  - counts 0..DIV-1 while en=1, wraps to 0.
  - tick asserts for one cycle when count==DIV-1 and en=1.
  - en=0 clears count to 0 next cycle; an in-flight operation still completes.
- IDLE:
  - tick → muestra_x<=adc_dato; go to LAUNCH.
  - no tick → stay.
- LAUNCH (exactly 1 cycle): Bandera=1; wait counter cleared; go to WAIT.
- WAIT:
  - Bandera=0; wait counter increments each cycle.
  - Band_Listo is sampled into a 1-bit history register that updates every cycle in every state.
  - Done = rising edge, i.e. Band_Listo=1 and previous=0. A level-high Listo at launch is not done, because the controller's Listo idles high.
  - Done → go to CAPT.
  - Wait counter reaching TIMEOUT-1 without done → error_to<=1; go to IDLE; no dac_valido.
  - Done and timeout in the same cycle → done wins.
- CAPT (1 cycle): dac_dato<=filt_dato, visible the following cycle together with dac_valido=1 for exactly one cycle; go to IDLE.
- Latency: tick to dac_valido = 3 + N cycles, where N = cycles in WAIT up to and including the done edge.
- Overrun:
  - tick while not in IDLE is dropped.
  - muestra_x is unchanged by a dropped tick.
  - ovr_cnt increments when the macro is defined.
- Simultaneous events:
  - clr_err has priority over a same-cycle error_to set or ovr_cnt increment.
  - A tick in the same cycle as CAPT is an overrun; the next tick is handled normally.
- Reset mid-operation: immediate return to IDLE. Bandera and dac_valido deassert asynchronously.
- Widths: no arithmetic on data; wait counter width = clog2(TIMEOUT)+1; divider width = clog2(DIV).

Optional Feature:
- Macro SEC_MUESTRAS_OVR_CNT_EN.
- Defined: ovr_cnt is an 8-bit saturating counter (holds at 255), incremented per dropped tick, cleared by clr_err or reset.
- Undefined: ovr_cnt is tied to 0 and no counter logic is synthesized; dropped ticks are silently discarded.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2, CAPT=2'd3) and the ovr_cnt width constant (8).
- One sub-module: gen_tick_muestreo (DIV divider plus en gating, outputs tick). The FSM stays in the top module.

Test Plan (DIV=8, TIMEOUT=10, W=16):
- adc_dato=16'h1234 at tick; responder model raises Band_Listo 6 cycles after Bandera and presents filt_dato=16'hBEEF → exactly one Bandera pulse; muestra_x=16'h1234; dac_valido one cycle with dac_dato=16'hBEEF at tick+9.
- Band_Listo held high from reset and never drops → no done detected; error_to=1 after 10 WAIT cycles; dac_valido never asserts; next tick launches again.
- Responder takes 12 cycles (longer than DIV) with the macro defined → ovr_cnt=1 per dropped tick; muestra_x unchanged by the dropped tick.
- Pulse clr_err while error_to=1 and ovr_cnt=3 → both 0 the next cycle; clr_err coincident with a timeout cycle → error_to stays 0.
- rst_n low for 1 cycle during WAIT → all outputs 0 immediately; after release, the first tick occurs at cycle DIV.
- en dropped mid-WAIT → current transaction completes with dac_valido; no further Bandera until en is high again for DIV cycles.
